// File: rtl/tetris_pkg.sv
// tetris_pkg: board geometry, piece encodings and board_writer FSM states
package tetris_pkg;
    localparam int BOARD_W  = 10;
    localparam int BOARD_H  = 24;
    localparam int DATA_W   = 6;
    localparam int ADDR_W   = 8;
    localparam int TOP_ROWS = 4;
    typedef enum logic [2:0] {
        BLK_I = 3'd0,
        BLK_O = 3'd1,
        BLK_T = 3'd2,
        BLK_S = 3'd3,
        BLK_Z = 3'd4,
        BLK_J = 3'd5,
        BLK_L = 3'd6
    } block_t;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_SCAN,
        S_SHIFT,
        S_CLR0,
        S_DONE
    } state_t;
endpackage

// File: rtl/board_writer_if.sv
// board_writer_if: piece request, board RAM port and status of the board writer
interface board_writer_if;
    import tetris_pkg::*;
    logic              start;
    logic [4:0]        X_anchor;
    logic [5:0]        Y_anchor;
    logic [2:0]        block;
    logic [1:0]        curr_rotation;
    logic [DATA_W-1:0] colour;
    logic [DATA_W-1:0] ram_Q;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic              busy;
    logic              complete;
    logic [2:0]        lines_cleared;
    logic              top_out;
    modport master (
        output start, X_anchor, Y_anchor, block, curr_rotation, colour, ram_Q,
        input  ram_addr, ram_data, ram_wren, busy, complete, lines_cleared, top_out
    );
    modport slave (
        input  start, X_anchor, Y_anchor, block, curr_rotation, colour, ram_Q,
        output ram_addr, ram_data, ram_wren, busy, complete, lines_cleared, top_out
    );
endinterface

// File: rtl/board_addr.sv
// board_addr: linear board address y*10+x built from shifts and adds
module board_addr
    import tetris_pkg::*;
(
    input  logic [ADDR_W-1:0] x,
    input  logic [ADDR_W-1:0] y,
    output logic [ADDR_W-1:0] addr
);
    assign addr = (y << 3) + (y << 1) + x;
endmodule

// File: rtl/lut.sv
// lut: per-cell (dx,dy) offsets of a tetromino inside its 4x4 box, 2 bits per cell
module lut
    import tetris_pkg::*;
(
    input  logic [2:0] block,
    input  logic [1:0] curr_rotation,
    output logic [7:0] coord_x,
    output logic [7:0] coord_y
);
    logic [7:0] bx, by;
    always_comb begin
        bx = 8'he4;
        by = 8'h00;
        case (block)
            BLK_O:   begin bx = 8'h44; by = 8'h50; end
            BLK_T:   begin bx = 8'h64; by = 8'h40; end
            BLK_S:   begin bx = 8'h49; by = 8'h50; end
            BLK_Z:   begin bx = 8'h94; by = 8'h50; end
            BLK_J:   begin bx = 8'h90; by = 8'h54; end
            BLK_L:   begin bx = 8'h92; by = 8'h54; end
            default: ;
        endcase
    end
    // a quarter turn maps (x,y) to (y,3-x), and 3-x on two bits is ~x
    assign coord_x = curr_rotation == 2'd0 ? bx : curr_rotation == 2'd1 ? by : curr_rotation == 2'd2 ? ~bx : ~by;
    assign coord_y = curr_rotation == 2'd0 ? by : curr_rotation == 2'd1 ? ~bx : curr_rotation == 2'd2 ? ~by : bx;
endmodule

// File: rtl/board_writer.sv
// board_writer: commits a locked piece to board RAM and collapses full rows; BOARD_WRITER_TOPOUT_EN enables top_out
module board_writer
    import tetris_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    board_writer_if.slave bus
);
    state_t            state, nxt;
    logic [3:0]        cnt, cnt_n;
    logic [4:0]        r, r_n, k, k_n;
    logic              ph, ph_n, inc, accept, cell_ok;
    logic [4:0]        xa;
    logic [5:0]        ya;
    logic [2:0]        blk, lines;
    logic [1:0]        rot;
    logic [DATA_W-1:0] col;
    logic [ADDR_W-1:0] cx, cy, wx, wy, ax, ay;

    lut u_lut (.block(blk), .curr_rotation(rot), .coord_x(cx), .coord_y(cy));
    board_addr u_addr (.x(ax), .y(ay), .addr(bus.ram_addr));

    assign accept = state == S_IDLE && bus.start;
    assign wx = {3'd0, xa} + {6'd0, cx[{cnt[1:0], 1'b0} +: 2]};
    assign wy = {2'd0, ya} + {6'd0, cy[{cnt[1:0], 1'b0} +: 2]};
    assign cell_ok = wx < 8'(BOARD_W) && wy < 8'(BOARD_H);
    assign bus.busy = state != S_IDLE && state != S_DONE;
    assign bus.complete = state == S_DONE;
    assign bus.lines_cleared = lines;

    always_comb begin
        nxt = state;
        cnt_n = cnt;
        r_n = r;
        k_n = k;
        ph_n = ph;
        inc = 1'b0;
        ax = '0;
        ay = '0;
        bus.ram_data = '0;
        bus.ram_wren = 1'b0;
        case (state)
            S_IDLE: begin
                nxt = accept ? S_WRITE : S_IDLE;
                cnt_n = '0;
            end
            S_WRITE: begin
                ax = wx;
                ay = wy;
                bus.ram_data = col;
                bus.ram_wren = cell_ok;
                cnt_n = cnt == 4'd3 ? 4'd0 : cnt + 4'd1;
                r_n = 5'(BOARD_H - 1);
                nxt = cnt == 4'd3 ? S_SCAN : S_WRITE;
            end
            S_SCAN: begin
                // ram_Q lags the address by a cycle, so cycle cnt judges cell cnt-1
                ax = {4'd0, cnt == 4'd10 ? 4'd0 : cnt};
                ay = {3'd0, r};
                cnt_n = cnt + 4'd1;
                if (cnt != 4'd0 && bus.ram_Q == '0) begin
                    cnt_n = '0;
                    r_n = r - 5'd1;
                    nxt = r == 5'd0 ? S_DONE : S_SCAN;
                end else if (cnt == 4'd10) begin
                    cnt_n = '0;
                    inc = 1'b1;
                    k_n = r;
                    ph_n = 1'b0;
                    nxt = r == 5'd0 ? S_CLR0 : S_SHIFT;
                end
            end
            S_SHIFT: begin
                ax = {4'd0, cnt};
                ay = {3'd0, ph ? k : k - 5'd1};
                bus.ram_data = bus.ram_Q;
                bus.ram_wren = ph;
                ph_n = ~ph;
                if (ph) begin
                    cnt_n = cnt == 4'd9 ? 4'd0 : cnt + 4'd1;
                    k_n = cnt == 4'd9 ? k - 5'd1 : k;
                    nxt = cnt == 4'd9 && k == 5'd1 ? S_CLR0 : S_SHIFT;
                end
            end
            S_CLR0: begin
                ax = {4'd0, cnt};
                bus.ram_wren = 1'b1;
                cnt_n = cnt == 4'd9 ? 4'd0 : cnt + 4'd1;
                nxt = cnt == 4'd9 ? S_SCAN : S_CLR0;
            end
            S_DONE: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt <= '0;
            r <= '0;
            k <= '0;
            ph <= 1'b0;
            xa <= '0;
            ya <= '0;
            blk <= '0;
            rot <= '0;
            col <= '0;
            lines <= '0;
        end else begin
            state <= nxt;
            cnt <= cnt_n;
            r <= r_n;
            k <= k_n;
            ph <= ph_n;
            if (accept) begin
                xa <= bus.X_anchor;
                ya <= bus.Y_anchor;
                blk <= bus.block;
                rot <= bus.curr_rotation;
                col <= bus.colour;
                lines <= '0;
            end else if (inc && lines != 3'd7) begin
                lines <= lines + 3'd1;
            end
        end
    end

`ifdef BOARD_WRITER_TOPOUT_EN
    logic hit, top;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit <= 1'b0;
            top <= 1'b0;
        end else if (accept) begin
            hit <= 1'b0;
            top <= 1'b0;
        end else begin
            if (state == S_WRITE && cell_ok && wy < 8'(TOP_ROWS))
                hit <= 1'b1;
            if (nxt == S_DONE)
                top <= hit;
        end
    end
    assign bus.top_out = top;
`else
    assign bus.top_out = 1'b0;
`endif
endmodule

// File: tb/tb_board_writer.sv
// tb_board_writer: scoreboard bench for board_writer with a behavioural board RAM
module tb_board_writer;
    import tetris_pkg::*;
`ifdef BOARD_WRITER_TOPOUT_EN
    localparam bit TOPEN = 1'b1;
`else
    localparam bit TOPEN = 1'b0;
`endif
    typedef struct packed { logic [7:0] a; logic [5:0] d; } wr_t;
    typedef struct packed { logic [2:0] l; logic t; } cm_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic ld = 1'b0;
    logic [5:0] mem [240];
    logic [5:0] img [240];
    logic [5:0] gold [240];
    logic [5:0] q;
    wr_t wq[$];
    cm_t cq[$];
    wr_t e;
    cm_t c;
    int checks = 0;
    int errors = 0;

    board_writer_if bus();
    board_writer dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;
    assign bus.ram_Q = q;

    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 240; i++) mem[i] <= img[i];
        end else if (bus.ram_wren && bus.ram_addr < 8'd240) begin
            mem[bus.ram_addr] <= bus.ram_data;
        end
        q <= bus.ram_addr < 8'd240 ? mem[bus.ram_addr] : 6'd0;
    end

    always @(negedge clk) begin
        if (resetn && bus.ram_wren) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr=%0d data=%0d, expected no write", bus.ram_addr, bus.ram_data);
            end else begin
                e = wq.pop_front();
                if (bus.ram_addr != e.a || bus.ram_data != e.d) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%0d, expected addr=%0d data=%0d", bus.ram_addr, bus.ram_data, e.a, e.d);
                end
            end
        end
        if (resetn && bus.complete) begin
            checks++;
            if (cq.size() == 0) begin
                errors++;
                $display("FAIL complete_unexpected: got complete=1, expected 0");
            end else begin
                c = cq.pop_front();
                if (bus.lines_cleared != c.l || bus.top_out != c.t || wq.size() != 0) begin
                    errors++;
                    $display("FAIL complete: got lines=%0d top=%0d pending=%0d, expected lines=%0d top=%0d pending=0", bus.lines_cleared, bus.top_out, wq.size(), c.l, c.t);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic blank();
        for (int i = 0; i < 240; i++) img[i] = 6'd0;
    endtask

    task automatic put(input int x, input int y, input logic [5:0] v);
        img[y * 10 + x] = v;
    endtask

    task automatic load();
        for (int i = 0; i < 240; i++) gold[i] = img[i];
        @(negedge clk) ld = 1'b1;
        @(negedge clk) ld = 1'b0;
    endtask

    task automatic predict(input int x, input int y, input logic [2:0] b, input int rot, input logic [5:0] col, input int exp_l, input bit exp_t);
        int dx[4];
        int dy[4];
        int xx, yy, r;
        bit full;
        if (b == BLK_O) begin dx = '{0, 1, 0, 1}; dy = '{0, 0, 1, 1}; end
        else if (rot == 0) begin dx = '{0, 1, 2, 3}; dy = '{0, 0, 0, 0}; end
        else begin dx = '{0, 0, 0, 0}; dy = '{3, 2, 1, 0}; end
        for (int i = 0; i < 4; i++) begin
            xx = x + dx[i];
            yy = y + dy[i];
            if (xx < 10 && yy < 24) begin
                wq.push_back('{8'(yy * 10 + xx), col});
                gold[yy * 10 + xx] = col;
            end
        end
        r = 23;
        while (1) begin
            full = 1'b1;
            for (int i = 0; i < 10; i++) if (gold[r * 10 + i] == 6'd0) full = 1'b0;
            if (full) begin
                for (int kk = r; kk >= 1; kk--)
                    for (int i = 0; i < 10; i++) begin
                        gold[kk * 10 + i] = gold[(kk - 1) * 10 + i];
                        wq.push_back('{8'(kk * 10 + i), gold[kk * 10 + i]});
                    end
                for (int i = 0; i < 10; i++) begin
                    gold[i] = 6'd0;
                    wq.push_back('{8'(i), 6'd0});
                end
            end else if (r == 0) begin
                break;
            end else begin
                r--;
            end
        end
        cq.push_back('{3'(exp_l), exp_t});
    endtask

    task automatic drive(input int x, input int y, input logic [2:0] b, input int rot, input logic [5:0] col);
        bus.X_anchor = 5'(x);
        bus.Y_anchor = 6'(y);
        bus.block = b;
        bus.curr_rotation = 2'(rot);
        bus.colour = col;
    endtask

    task automatic start_op(input int x, input int y, input logic [2:0] b, input int rot, input logic [5:0] col, input int exp_l, input bit exp_t);
        predict(x, y, b, rot, col, exp_l, exp_t);
        @(negedge clk);
        drive(x, y, b, rot, col);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        chk("lines_clear_on_start", bus.lines_cleared, 0);
        chk("top_clear_on_start", bus.top_out, 0);
    endtask

    task automatic check_board(input string name);
        int bad = -1;
        for (int i = 239; i >= 0; i--) if (mem[i] != gold[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_board: addr %0d got %0d, expected %0d", name, bad, mem[bad], gold[bad]);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.complete && n < 8000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, bus.complete, 1);
        #1;
        check_board(name);
    endtask

    initial begin
        bus.start = 1'b0;
        drive(0, 0, BLK_I, 0, 6'd0);
        blank();
        repeat (3) @(negedge clk);
        chk("rst_wren", bus.ram_wren, 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_data", bus.ram_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_complete", bus.complete, 0);
        chk("rst_lines", bus.lines_cleared, 0);
        chk("rst_top", bus.top_out, 0);
        resetn = 1'b1;

        blank();
        load();
        start_op(4, 22, BLK_O, 0, 6'd5, 0, 1'b0);
        bus.start = 1'b1;
        bus.colour = 6'd7;
        bus.X_anchor = 5'd0;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        wait_done("o_piece");

        blank();
        for (int i = 0; i < 6; i++) put(i, 23, 6'(i + 1));
        put(0, 22, 6'd3);
        put(2, 22, 6'd3);
        load();
        start_op(6, 23, BLK_I, 0, 6'd2, 1, 1'b0);
        wait_done("i_horiz");

        blank();
        for (int y = 20; y < 24; y++) for (int x = 0; x < 9; x++) put(x, y, 6'((y + x) % 7 + 1));
        for (int y = 16; y < 20; y++) put(y - 16, y, 6'd4);
        load();
        start_op(9, 20, BLK_I, 1, 6'd6, 4, 1'b0);
        wait_done("i_vert_four");

        blank();
        for (int x = 1; x < 10; x++) begin put(x, 23, 6'd1); put(x, 22, 6'd2); end
        for (int x = 3; x < 6; x++) put(x, 21, 6'd3);
        load();
        start_op(0, 20, BLK_I, 1, 6'd7, 2, 1'b0);
        wait_done("double");

        blank();
        load();
        start_op(9, 23, BLK_O, 0, 6'd9, 0, 1'b0);
        wait_done("edge_skip");
        start_op(31, 63, BLK_I, 0, 6'd1, 0, 1'b0);
        wait_done("all_skip");

        blank();
        for (int x = 0; x < 8; x++) put(x, 0, 6'(x + 1));
        load();
        start_op(8, 0, BLK_O, 0, 6'd3, 1, TOPEN);
        wait_done("row0");

        blank();
        for (int i = 0; i < 6; i++) put(i, 23, 6'(i + 1));
        put(0, 22, 6'd3);
        load();
        start_op(6, 23, BLK_I, 0, 6'd2, 1, 1'b0);
        repeat (30) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("abort_wren", bus.ram_wren, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_complete", bus.complete, 0);
        chk("abort_lines", bus.lines_cleared, 0);
        wq.delete();
        cq.delete();
        resetn = 1'b1;

        blank();
        load();
        start_op(0, 1, BLK_O, 0, 6'd12, 0, TOPEN);
        wait_done("top_piece");
        predict(2, 10, BLK_O, 0, 6'd4, 0, 1'b0);
        drive(2, 10, BLK_O, 0, 6'd4);
        bus.start = 1'b1;
        @(negedge clk);
        chk("start_at_complete_ignored", bus.busy, 0);
        chk("top_held", bus.top_out, TOPEN);
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_after_complete", bus.busy, 1);
        chk("top_cleared", bus.top_out, 0);
        wait_done("after_complete");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
